mii_tx_frame_checker: RTL and testbench
=======================================

# mii_tx_frame_checker

Inline monitor on the target-side MII transmit bus, clocked by `tx_clk`, sitting directly downstream of the RX→TX MII passthrough. It observes `tx_en`, `txd` and `tx_er` exactly as they are driven to the target PHY, without driving them. For each frame it checks the preamble and SFD, the FCS (CRC-32), the length, nibble alignment and PHY error signalling. It reports a per-frame status pulse and keeps good and bad frame counters for host readout.

## Interface
- `PREAMBLE_MIN`, 4: minimum count of 0x5 nibbles required before the SFD nibble.
- `MIN_BYTES`, 64: minimum legal frame length in bytes, destination address through FCS inclusive.
- `MAX_BYTES`, 1522: maximum legal frame length in bytes, same span.
- `tx_clk` input 1: sole clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tx_en` input 1: monitored MII transmit enable.
- `txd` input 4: monitored MII transmit nibble; `txd[0]` is the first bit on the wire.
- `tx_er` input 1: monitored MII transmit error.
- `frame_done` output 1: one-cycle pulse; the status outputs below are valid and updated on this cycle.
- `frame_ok` output 1: last frame had no error flags set.
- `err_preamble` output 1: last frame had a bad or short preamble, or a missing SFD.
- `err_crc` output 1: last frame had an FCS residue mismatch.
- `err_len` output 1: last frame length was below `MIN_BYTES` or above `MAX_BYTES`.
- `err_align` output 1: last frame had an odd number of nibbles after the SFD.
- `err_phy` output 1: `tx_er` was sampled high at least once while `tx_en` = 1.
- `frame_bytes` output 11: byte count of the last frame after the SFD; saturates at 2047.
- `good_count` output 16: count of frames with `frame_ok` = 1; wraps at 0xFFFF→0.
- `bad_count` output 16: count of frames with `frame_ok` = 0; wraps.

## Operation
- **Reset:** all outputs are 0 and the state is HUNT. The CRC register is 0xFFFFFFFF and the nibble and preamble counters are 0.
- **State machine:** states are HUNT, IDLE, PREAMBLE, DATA, DROP. `tx_en`, `txd` and `tx_er` are sampled on each edge.
- **HUNT:** moves to IDLE on the first `tx_en` = 0. This prevents a frame already in progress at reset release from being counted.
- **IDLE:**
  - `tx_en` = 1 and `txd` = 0x5 → PREAMBLE, preamble count = 1.
  - `tx_en` = 1 and any other nibble → DROP with `err_preamble` latched.
- **PREAMBLE:**
  - 0x5 → count + 1, saturating at 15.
  - 0xD with count ≥ `PREAMBLE_MIN` → DATA; the CRC register and nibble count are cleared to their initial values.
  - 0xD with a short count, or any other nibble → DROP with `err_preamble` latched.
  - `tx_en` = 0 → frame ends with `err_preamble`.
- **DATA:**
  - Each nibble with `tx_en` = 1 updates the CRC and increments the 12-bit nibble count, which saturates at 4095.
  - The CRC is reflected, polynomial 0xEDB88320, initial value 0xFFFFFFFF, four bit-serial steps per nibble, `txd[0]` first.
  - The FCS nibbles are included in the CRC.
- **DROP:** consumes nibbles until `tx_en` = 0, then ends the frame.
- **`tx_er`:** while `tx_en` = 1, `tx_er` = 1 latches `err_phy` in any of PREAMBLE, DATA or DROP. The frame continues.
- **End of frame** (first `tx_en` = 0 sample in PREAMBLE, DATA or DROP):
  - `err_crc` = (CRC register ≠ 0xDEBB20E3). Evaluated only for frames that ended from DATA; otherwise 0.
  - `err_align` = nibble count[0].
  - `frame_bytes` = nibble count >> 1, saturated to 2047.
  - `err_len` = bytes < `MIN_BYTES` or bytes > `MAX_BYTES`. Evaluated only for frames that ended from DATA.
  - `frame_ok` = NOR of the five error flags.
  - Exactly one of `good_count` / `bad_count` increments. The next state is IDLE.
- **Back-to-back frames:** a single-cycle `tx_en` gap is legal. The edge that ends frame N sees `tx_en` = 0, and frame N+1 can start on the following edge.

## Timing
- The end of frame is detected on edge k, the first edge that samples `tx_en` = 0.
- On edge k: `frame_done` rises, and all status outputs and counters update together.
- On edge k+1: `frame_done` falls. Status outputs hold until the next `frame_done`.
- Latency from `tx_en` falling to `frame_done` is 1 cycle. No status output changes except on a `frame_done` edge.
- **Asynchronous reset mid-frame:** all outputs and the counters clear immediately. No `frame_done` is produced for the interrupted frame. HUNT then discards the remainder of that frame.
- `tx_en` = 0 while in IDLE or HUNT produces no `frame_done`.

## Test plan
1. **Good minimum frame.** Drive 15×0x5, then 0xD, then 60 payload bytes + a correct FCS from the bench model. Required: one `frame_done`, `frame_ok` = 1, `frame_bytes` = 64, `good_count` = 1.
2. **Corrupted FCS.** Same frame with FCS bit 0 flipped. Required: `err_crc` = 1, `frame_ok` = 0, `bad_count` = 1, `good_count` unchanged.
3. **Length and alignment errors.** A 63-byte frame with valid FCS → `err_len` = 1, `frame_bytes` = 63. A 1523-byte frame → `err_len` = 1. A valid 64-byte frame plus one dribble nibble → `err_align` = 1.
4. **Preamble error and `tx_er`.** A 3×0x5 preamble with `PREAMBLE_MIN` = 4 → `err_preamble` = 1 with `err_crc` = 0. A preamble containing 0x7 → `err_preamble` = 1. `tx_er` pulsed for one cycle mid-payload → `err_phy` = 1, `frame_bytes` still correct.
5. **Back-to-back good frames.** Two good frames separated by a 1-cycle gap. Required: two `frame_done` pulses, `good_count` = 2. Also preload `good_count` = 0xFFFF and send one good frame → `good_count` = 0.
6. **Reset mid-frame.** Assert `reset` at payload byte 20 and release while `tx_en` = 1. Required: no `frame_done`, all counters = 0, and the next complete good frame gives `good_count` = 1.

Source files
------------

// File: rtl/mii_tx_frame_checker.sv
// mii_tx_frame_checker
// Passive monitor on the target-side MII transmit bus. It never drives the bus.
// For each frame it checks the preamble/SFD, the FCS (CRC-32 residue), the
// frame length, nibble alignment and tx_er signalling. It reports the result
// with a one-cycle frame_done pulse and keeps good/bad frame counters.
//
// Ports
//   tx_clk       : sole clock, rising edge
//   reset        : asynchronous, active-high
//   tx_en/txd/tx_er : monitored MII transmit signals (txd[0] first on the wire)
//   frame_done   : one-cycle pulse; status outputs update on the same edge
//   frame_ok     : last frame had no error flag set
//   err_preamble : bad or short preamble, or missing SFD
//   err_crc      : FCS residue mismatch (frames that reached DATA only)
//   err_len      : byte count outside [MIN_BYTES, MAX_BYTES] (DATA frames only)
//   err_align    : odd number of nibbles after the SFD
//   err_phy      : tx_er seen high while tx_en was high
//   frame_bytes  : bytes after the SFD, saturating at 2047
//   good_count   : frames with frame_ok = 1 (wraps)
//   bad_count    : frames with frame_ok = 0 (wraps)
module mii_tx_frame_checker #(
  parameter int PREAMBLE_MIN = 4,
  parameter int MIN_BYTES    = 64,
  parameter int MAX_BYTES    = 1522
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        tx_en,
  input  logic [3:0]  txd,
  input  logic        tx_er,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_preamble,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_align,
  output logic        err_phy,
  output logic [10:0] frame_bytes,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam logic [2:0] HUNT     = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] PREAMBLE = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] DROP     = 3'd4;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  // Register value after clocking in data plus its own (complemented) FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN);
  localparam logic [10:0] MIN_B   = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_B   = 11'(MAX_BYTES);

  logic [2:0]  state;
  logic [31:0] crc;
  logic [11:0] nib_cnt;
  logic [3:0]  pre_cnt;
  logic        pre_bad;
  logic        phy_bad;

  // Reflected CRC-32, four bit-serial steps, txd[0] first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] c_in,
                                             input logic [3:0]  d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] n);
    return (n == 12'hFFF) ? n : n + 12'd1;
  endfunction

  function automatic logic [10:0] sat_bytes(input logic [11:0] n);
    logic [11:0] h;
    h = {1'b0, n[11:1]};
    return (h > 12'h7FF) ? 11'h7FF : h[10:0];
  endfunction

  logic        end_frame;
  logic        from_data;
  logic [10:0] end_bytes;
  logic        end_pre;
  logic        end_crc;
  logic        end_len;
  logic        end_align;
  logic        end_ok;

  always_comb begin
    end_frame = 1'b0;
    if (!tx_en && (state == PREAMBLE || state == DATA || state == DROP))
      end_frame = 1'b1;
    from_data = (state == DATA);
    end_bytes = sat_bytes(nib_cnt);
    // Ending while still in the preamble means the SFD never arrived.
    end_pre   = pre_bad || (state == PREAMBLE);
    end_crc   = from_data && (crc != CRC_RESIDUE);
    end_len   = from_data && ((end_bytes < MIN_B) || (end_bytes > MAX_B));
    end_align = nib_cnt[0];
    end_ok    = !(end_pre || end_crc || end_len || end_align || phy_bad);
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      crc          <= CRC_INIT;
      nib_cnt      <= 12'd0;
      pre_cnt      <= 4'd0;
      pre_bad      <= 1'b0;
      phy_bad      <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      err_preamble <= 1'b0;
      err_crc      <= 1'b0;
      err_len      <= 1'b0;
      err_align    <= 1'b0;
      err_phy      <= 1'b0;
      frame_bytes  <= 11'd0;
      good_count   <= 16'd0;
      bad_count    <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        HUNT: begin
          // Discard any frame already in flight when reset was released.
          if (!tx_en) state <= IDLE;
        end
        IDLE: begin
          if (tx_en) begin
            crc     <= CRC_INIT;
            nib_cnt <= 12'd0;
            pre_cnt <= 4'd1;
            phy_bad <= tx_er;
            pre_bad <= (txd != 4'h5);
            state   <= (txd == 4'h5) ? PREAMBLE : DROP;
          end
        end
        PREAMBLE: begin
          if (tx_en) begin
            if (tx_er) phy_bad <= 1'b1;
            if (txd == 4'h5) begin
              if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
            end else if (txd == 4'hD && pre_cnt >= PRE_MIN) begin
              crc     <= CRC_INIT;
              nib_cnt <= 12'd0;
              state   <= DATA;
            end else begin
              pre_bad <= 1'b1;
              state   <= DROP;
            end
          end
        end
        DATA: begin
          if (tx_en) begin
            if (tx_er) phy_bad <= 1'b1;
            crc     <= crc_nibble(crc, txd);
            nib_cnt <= sat_inc12(nib_cnt);
          end
        end
        DROP: begin
          if (tx_en && tx_er) phy_bad <= 1'b1;
        end
        default: state <= HUNT;
      endcase

      if (end_frame) begin
        state        <= IDLE;
        frame_done   <= 1'b1;
        frame_ok     <= end_ok;
        err_preamble <= end_pre;
        err_crc      <= end_crc;
        err_len      <= end_len;
        err_align    <= end_align;
        err_phy      <= phy_bad;
        frame_bytes  <= end_bytes;
        if (end_ok) good_count <= good_count + 16'd1;
        else        bad_count  <= bad_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mii_tx_frame_checker.sv
module tb_mii_tx_frame_checker;

  logic        tx_clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic [3:0]  txd;
  logic        tx_er;
  logic        frame_done;
  logic        frame_ok;
  logic        err_preamble;
  logic        err_crc;
  logic        err_len;
  logic        err_align;
  logic        err_phy;
  logic [10:0] frame_bytes;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;

  logic [7:0] fb [0:2047];

  mii_tx_frame_checker #(
    .PREAMBLE_MIN(4),
    .MIN_BYTES(64),
    .MAX_BYTES(1522)
  ) dut (
    .tx_clk(tx_clk),
    .reset(reset),
    .tx_en(tx_en),
    .txd(txd),
    .tx_er(tx_er),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .err_preamble(err_preamble),
    .err_crc(err_crc),
    .err_len(err_len),
    .err_align(err_align),
    .err_phy(err_phy),
    .frame_bytes(frame_bytes),
    .good_count(good_count),
    .bad_count(bad_count)
  );

  always #5 tx_clk = ~tx_clk;

  // Count frame_done pulses, sampled just after each rising edge.
  always begin
    @(posedge tx_clk);
    #1;
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference Ethernet CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Fill fb with n bytes: payload followed by FCS (sent LSB byte first).
  task automatic build(input int n, input bit corrupt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      fb[i] = 8'(i * 7 + 3);
      c = crc_byte(c, fb[i]);
    end
    c = ~c;
    fb[n-4] = c[7:0];
    fb[n-3] = c[15:8];
    fb[n-2] = c[23:16];
    fb[n-1] = c[31:24];
    if (corrupt) fb[n-4][0] = ~fb[n-4][0];
  endtask

  task automatic drive(input logic [3:0] d, input logic er);
    @(negedge tx_clk);
    tx_en = 1'b1;
    txd   = d;
    tx_er = er;
  endtask

  // npre 0x5 nibbles (index bad_idx replaced by 0x7), SFD, nbytes of fb,
  // extra 0x0 dribble nibbles, then tx_en low for one sample.
  task automatic send(input int npre, input int bad_idx, input int nbytes,
                      input int extra, input int er_nib, input int rst_byte);
    for (int i = 0; i < npre; i++) drive((i == bad_idx) ? 4'h7 : 4'h5, 1'b0);
    drive(4'hD, 1'b0);
    for (int j = 0; j < 2 * nbytes; j++) begin
      if (j == 2 * rst_byte) begin
        @(negedge tx_clk);
        reset = 1'b1;
        #1;
        check("rst_good_count", 32'(good_count), 32'd0);
        check("rst_bad_count", 32'(bad_count), 32'd0);
        check("rst_frame_bytes", 32'(frame_bytes), 32'd0);
        check("rst_flags", {26'd0, frame_ok, err_preamble, err_crc, err_len, err_align, err_phy}, 32'd0);
      end
      if (j == 2 * rst_byte + 4) reset = 1'b0;
      drive((j % 2 == 0) ? fb[j/2][3:0] : fb[j/2][7:4], (j == er_nib) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < extra; k++) drive(4'h0, 1'b0);
    @(negedge tx_clk);
    tx_en = 1'b0;
    tx_er = 1'b0;
    txd   = 4'h0;
  endtask

  task automatic settle();
    repeat (3) @(negedge tx_clk);
  endtask

  initial begin
    reset = 1'b1;
    tx_en = 1'b0;
    txd   = 4'h0;
    tx_er = 1'b0;
    repeat (3) @(negedge tx_clk);
    check("reset_outputs", {15'd0, frame_done, frame_ok, err_preamble, err_crc, err_len, err_align, err_phy, frame_bytes}, 32'd0);
    check("reset_counts", {good_count, bad_count}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge tx_clk);
    check("idle_no_done", 32'(done_cnt), 32'd0);

    // 1. good minimum frame
    build(64, 1'b0);
    send(15, -1, 64, 0, -1, -1);
    settle();
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_ok", 32'(frame_ok), 32'd1);
    check("t1_bytes", 32'(frame_bytes), 32'd64);
    check("t1_good", 32'(good_count), 32'd1);

    // 2. corrupted FCS
    build(64, 1'b1);
    send(15, -1, 64, 0, -1, -1);
    settle();
    check("t2_crc", 32'(err_crc), 32'd1);
    check("t2_ok", 32'(frame_ok), 32'd0);
    check("t2_bad", 32'(bad_count), 32'd1);
    check("t2_good", 32'(good_count), 32'd1);

    // 3. length and alignment
    build(63, 1'b0);
    send(15, -1, 63, 0, -1, -1);
    settle();
    check("t3_short_len", 32'(err_len), 32'd1);
    check("t3_short_crc", 32'(err_crc), 32'd0);
    check("t3_short_bytes", 32'(frame_bytes), 32'd63);
    build(1523, 1'b0);
    send(15, -1, 1523, 0, -1, -1);
    settle();
    check("t3_long_len", 32'(err_len), 32'd1);
    check("t3_long_bytes", 32'(frame_bytes), 32'd1523);
    build(64, 1'b0);
    send(15, -1, 64, 1, -1, -1);
    settle();
    check("t3_align", 32'(err_align), 32'd1);
    check("t3_align_bytes", 32'(frame_bytes), 32'd64);
    check("t3_bad", 32'(bad_count), 32'd4);

    // 4. preamble errors and tx_er
    send(3, -1, 64, 0, -1, -1);
    settle();
    check("t4_short_pre", {err_preamble, err_crc, err_len, frame_ok}, {1'b1, 1'b0, 1'b0, 1'b0});
    send(15, 5, 64, 0, -1, -1);
    settle();
    check("t4_pre7", 32'(err_preamble), 32'd1);
    send(15, -1, 64, 0, 40, -1);
    settle();
    check("t4_phy", {err_phy, err_crc, err_preamble, frame_ok}, {1'b1, 1'b0, 1'b0, 1'b0});
    check("t4_phy_bytes", 32'(frame_bytes), 32'd64);
    check("t4_bad", 32'(bad_count), 32'd7);

    // 5. back-to-back good frames, then counter wrap
    d0 = done_cnt;
    send(15, -1, 64, 0, -1, -1);
    send(15, -1, 64, 0, -1, -1);
    settle();
    check("t5_two_done", 32'(done_cnt - d0), 32'd2);
    check("t5_good", 32'(good_count), 32'd3);
    check("t5_ok", 32'(frame_ok), 32'd1);
    force dut.good_count = 16'hFFFF;
    @(negedge tx_clk);
    release dut.good_count;
    send(15, -1, 64, 0, -1, -1);
    settle();
    check("t5_wrap", 32'(good_count), 32'd0);

    // 6. reset mid-frame
    d0 = done_cnt;
    send(15, -1, 64, 0, -1, 20);
    settle();
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_counts", {good_count, bad_count}, 32'd0);
    send(15, -1, 64, 0, -1, -1);
    settle();
    check("t6_good", 32'(good_count), 32'd1);
    check("t6_bad", 32'(bad_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
